// File: rtl/tow_match_controller.sv
// Tug-of-war match sequencer: serve, play, round-end holdoff and match over.
// It turns the two player press pulses into single move pulses, detects
// round wins at the edge LEDs, keeps both scores and re-centres the field.
module tow_match_controller #(
  parameter int WIN_SCORE = 7,
  parameter int HOLDOFF   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       L,
  input  logic       R,
  input  logic       LED9,
  input  logic       LED1,
  output logic       move_l,
  output logic       move_r,
  output logic       field_reset,
  output logic       round_active,
  output logic [2:0] user_score,
  output logic [2:0] comp_score,
  output logic       match_over,
  output logic       winner
);

  // A holdoff of 1 still needs a 1-bit counter that simply stays at 0.
  localparam int         CW       = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);
  localparam logic [2:0] WIN      = 3'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_ROUND_END,
    S_MATCH_OVER
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    user_reg, user_next;
  logic [2:0]    comp_reg, comp_next;
  logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          move_l_reg, move_l_next;
  logic          move_r_reg, move_r_next;
  logic          field_reset_reg, field_reset_next;

  // Only a press from exactly one player counts; a tie cancels both.
  logic l_only, r_only;
  assign l_only = L & ~R;
  assign r_only = R & ~L;

  // State, scores, holdoff counter and pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      user_reg        <= '0;
      comp_reg        <= '0;
      hold_cnt_reg    <= '0;
      move_l_reg      <= 1'b0;
      move_r_reg      <= 1'b0;
      field_reset_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      user_reg        <= user_next;
      comp_reg        <= comp_next;
      hold_cnt_reg    <= hold_cnt_next;
      move_l_reg      <= move_l_next;
      move_r_reg      <= move_r_next;
      field_reset_reg <= field_reset_next;
    end
  end

  // Next-state, scoring and pulse generation; pulses default low so each
  // event produces exactly one cycle.
  always_comb begin
    state_next       = state_reg;
    user_next        = user_reg;
    comp_next        = comp_reg;
    hold_cnt_next    = hold_cnt_reg;
    move_l_next      = 1'b0;
    move_r_next      = 1'b0;
    field_reset_next = 1'b0;
    case (state_reg)
      S_IDLE, S_MATCH_OVER: begin
        if (start) begin
          state_next       = S_SERVE;
          user_next        = '0;
          comp_next        = '0;
          field_reset_next = 1'b1;
        end
      end
      S_SERVE: begin
        state_next = S_PLAY;
      end
      S_PLAY: begin
        if (l_only) begin
          if (LED9) begin
            comp_next     = comp_reg + 3'd1;
            hold_cnt_next = HOLD_LOAD;
            state_next    = S_ROUND_END;
          end else begin
            move_l_next = 1'b1;
          end
        end else if (r_only) begin
          if (LED1) begin
            user_next     = user_reg + 3'd1;
            hold_cnt_next = HOLD_LOAD;
            state_next    = S_ROUND_END;
          end else begin
            move_r_next = 1'b1;
          end
        end
      end
      S_ROUND_END: begin
        if (hold_cnt_reg == '0) begin
          if (user_reg == WIN || comp_reg == WIN) begin
            state_next = S_MATCH_OVER;
          end else begin
            state_next       = S_SERVE;
            field_reset_next = 1'b1;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign move_l       = move_l_reg;
  assign move_r       = move_r_reg;
  assign field_reset  = field_reset_reg;
  assign user_score   = user_reg;
  assign comp_score   = comp_reg;
  assign round_active = (state_reg == S_PLAY);
  assign match_over   = (state_reg == S_MATCH_OVER);
  assign winner       = match_over && (user_reg == WIN);

endmodule

// File: tb/tb_tow_match_controller.sv
// Bench for tow_match_controller: directed match scenarios plus random play,
// checked every cycle against a rule-level model of the match.
module tb_tow_match_controller;

  localparam int WIN  = 7;
  localparam int HOLD = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_HOLD  = 3;
  localparam int PH_OVER  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, L, R, LED9, LED1;
  logic       move_l, move_r, field_reset, round_active, match_over, winner;
  logic [2:0] user_score, comp_score;

  int total = 0;
  int bad   = 0;

  // model of the match
  int m_phase       = PH_IDLE;
  int m_user        = 0;
  int m_comp        = 0;
  int m_hold_left   = 0;
  bit m_move_l      = 0;
  bit m_move_r      = 0;
  bit m_field_reset = 0;

  tow_match_controller #(.WIN_SCORE(WIN), .HOLDOFF(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .L(L), .R(R),
    .LED9(LED9), .LED1(LED1),
    .move_l(move_l), .move_r(move_r), .field_reset(field_reset),
    .round_active(round_active), .user_score(user_score),
    .comp_score(comp_score), .match_over(match_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_phase = PH_IDLE;
    m_user = 0;
    m_comp = 0;
    m_hold_left = 0;
    m_move_l = 0;
    m_move_r = 0;
    m_field_reset = 0;
  endtask

  // Match rules, advanced once per clock edge.
  always @(posedge clk) begin
    if (!reset) begin
      model_clear();
    end else begin
      m_move_l = 0;
      m_move_r = 0;
      m_field_reset = 0;
      case (m_phase)
        PH_IDLE, PH_OVER: begin
          if (start) begin
            m_user = 0;
            m_comp = 0;
            m_phase = PH_SERVE;
            m_field_reset = 1;
            $display("txn t=%0t new match serve", $time);
          end
        end
        PH_SERVE: m_phase = PH_PLAY;
        PH_PLAY: begin
          if (L && !R) begin
            if (LED9) begin
              m_comp++;
              m_phase = PH_HOLD;
              m_hold_left = HOLD;
              $display("txn t=%0t computer wins round, score %0d-%0d", $time, m_user, m_comp);
            end else begin
              m_move_l = 1;
            end
          end else if (R && !L) begin
            if (LED1) begin
              m_user++;
              m_phase = PH_HOLD;
              m_hold_left = HOLD;
              $display("txn t=%0t user wins round, score %0d-%0d", $time, m_user, m_comp);
            end else begin
              m_move_r = 1;
            end
          end
        end
        PH_HOLD: begin
          m_hold_left--;
          if (m_hold_left == 0) begin
            if (m_user == WIN || m_comp == WIN) begin
              m_phase = PH_OVER;
              $display("txn t=%0t match over, user %0d comp %0d", $time, m_user, m_comp);
            end else begin
              m_phase = PH_SERVE;
              m_field_reset = 1;
            end
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  always @(negedge reset) model_clear();

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("move_l", move_l, m_move_l);
    chk("move_r", move_r, m_move_r);
    chk("field_reset", field_reset, m_field_reset);
    chk("round_active", round_active, m_phase == PH_PLAY);
    chk("match_over", match_over, m_phase == PH_OVER);
    chk("winner", winner, (m_phase == PH_OVER) && (m_user == WIN));
    chk("user_score", user_score, m_user);
    chk("comp_score", comp_score, m_comp);
    chk("moves_exclusive", move_l && move_r, 0);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_play_or_over();
    int n = 0;
    while (!(round_active || match_over) && n < 12) begin
      tick();
      n++;
    end
    chk("wait_bound", int'(n < 12), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 0; L = 0; R = 0; LED9 = 0; LED1 = 0;
    repeat (3) tick();
    chk("rst_round_active", round_active, 0);
    chk("rst_field_reset", field_reset, 0);
    chk("rst_user", user_score, 0);
    chk("rst_match_over", match_over, 0);
    reset = 1'b1;

    // start -> field_reset on 2nd cycle, play from 3rd
    tick(); start = 1;
    tick(); start = 0;
    chk("serve_field_reset", field_reset, 1);
    chk("serve_round_active", round_active, 0);
    tick();
    chk("play_field_reset", field_reset, 0);
    chk("play_round_active", round_active, 1);
    chk("play_scores", user_score + comp_score, 0);

    // single move pulse, then tied presses cancel
    L = 1; tick(); L = 0;
    chk("lit_move_l", move_l, 1);
    tick();
    chk("lit_move_l_single", move_l, 0);
    L = 1; R = 1; tick(); L = 0; R = 0;
    chk("tie_move_l", move_l, 0);
    chk("tie_move_r", move_r, 0);
    chk("tie_user", user_score, 0);

    // user wins a round; presses during holdoff are dropped
    LED1 = 1; R = 1; tick(); R = 0; LED1 = 0;
    chk("uwin_user", user_score, 1);
    chk("uwin_move_r", move_r, 0);
    chk("uwin_round_active", round_active, 0);
    L = 1;
    repeat (3) begin
      tick();
      chk("hold_round_active", round_active, 0);
      chk("hold_field_reset", field_reset, 0);
      chk("hold_move_l", move_l, 0);
    end
    L = 0; tick();
    chk("reserve_field_reset", field_reset, 1);
    chk("reserve_move_l", move_l, 0);
    tick();
    chk("replay_round_active", round_active, 1);

    // computer takes seven rounds
    for (int k = 1; k <= WIN; k++) begin
      L = 1; LED9 = 1; tick(); L = 0; LED9 = 0;
      chk("cwin_comp", comp_score, k);
      chk("cwin_move_l", move_l, 0);
      wait_play_or_over();
    end
    chk("over_match_over", match_over, 1);
    chk("over_winner", winner, 0);
    chk("over_comp", comp_score, 7);
    chk("over_user", user_score, 1);
    L = 1; LED9 = 1; tick(); L = 0; R = 1; LED1 = 1; tick(); R = 0; LED9 = 0; LED1 = 0; tick();
    chk("over_hold_comp", comp_score, 7);
    chk("over_hold_user", user_score, 1);
    chk("over_hold_match", match_over, 1);

    // restart from match over; press during serve dropped
    start = 1; tick(); start = 0; L = 1;
    chk("restart_user", user_score, 0);
    chk("restart_comp", comp_score, 0);
    chk("restart_field_reset", field_reset, 1);
    tick(); L = 0;
    chk("serve_press_move_l", move_l, 0);
    chk("restart_round_active", round_active, 1);

    // random play
    repeat (3000) begin
      tick();
      start = ($urandom_range(0, 40) == 0);
      L     = ($urandom_range(0, 2) == 0);
      R     = ($urandom_range(0, 2) == 0);
      LED9  = ($urandom_range(0, 3) == 0);
      LED1  = ($urandom_range(0, 3) == 0);
    end
    tick(); start = 0; L = 0; R = 0; LED9 = 0; LED1 = 0;

    // reset in the middle of a holdoff with user_score = 3
    reset = 0; tick(); reset = 1; start = 1;
    tick(); start = 0;
    tick();
    for (int k = 1; k <= 3; k++) begin
      LED1 = 1; R = 1; tick(); R = 0; LED1 = 0;
      if (k < 3) wait_play_or_over();
    end
    tick();
    chk("pre_rst_user", user_score, 3);
    chk("pre_rst_round_active", round_active, 0);
    #1 reset = 0;
    #1;
    chk("async_user", user_score, 0);
    chk("async_comp", comp_score, 0);
    chk("async_round_active", round_active, 0);
    chk("async_match_over", match_over, 0);
    chk("async_pulses", {move_l, move_r, field_reset, winner}, 0);
    tick(); reset = 1;
    tick();
    chk("post_rst_idle", round_active, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tow_match_controller.md
Name: tow_match_controller

Overview:
- Sequences a full tug-of-war match around the playfield light bar: serve, play, round-end holdoff, match over.
- Arbitrates the two player presses into single move pulses for the playfield.
- Detects round wins at the edge LEDs, keeps both scores, and re-centres the playfield between rounds.
- Sits between the edge-detected key inputs and the playfield/score display logic.

Parameters:
WIN_SCORE, 7, rounds needed to win the match (1..7)
HOLDOFF, 4, cycles spent in ROUND_END before the next serve (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  level; begins a match from IDLE or MATCH_OVER
L  input  1  one-cycle left-player (computer) press pulse
R  input  1  one-cycle right-player (user) press pulse
LED9  input  1  playfield leftmost light lit
LED1  input  1  playfield rightmost light lit
move_l  output  1  registered one-cycle pulse: shift light left
move_r  output  1  registered one-cycle pulse: shift light right
field_reset  output  1  one-cycle pulse: re-centre playfield
round_active  output  1  high only in PLAY
user_score  output  3  rounds won by user
comp_score  output  3  rounds won by computer
match_over  output  1  high in MATCH_OVER
winner  output  1  valid while match_over: 1 = user, 0 = computer

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, scores 0, holdoff counter 0.
- States: IDLE, SERVE, PLAY, ROUND_END, MATCH_OVER. All state, count and output registers update on posedge clk.
- IDLE:
  - start=1 -> SERVE; scores cleared to 0.
  - L/R ignored.
- SERVE: lasts exactly 1 cycle.
  - field_reset=1 during the cycle following entry (registered).
  - Unconditional -> PLAY.
  - Presses during SERVE are dropped.
- PLAY: round_active=1. Each edge, inputs are sampled and arbitrated:
  - L=1 and R=1 together: both dropped. No move, no win.
  - L=1, R=0, LED9=0: move_l=1 the next cycle.
  - R=1, L=0, LED1=0: move_r=1 the next cycle.
  - L=1, R=0, LED9=1: computer wins the round. comp_score+1, no move pulse, -> ROUND_END.
  - R=1, L=0, LED1=1: user wins the round. user_score+1, no move pulse, -> ROUND_END.
  - LED9 and LED1 both 1: a single qualifying press still wins for its own side.
  - start is ignored in PLAY.
- ROUND_END:
  - Holdoff counter loads HOLDOFF-1 on entry and decrements each cycle.
  - At 0: if user_score==WIN_SCORE or comp_score==WIN_SCORE -> MATCH_OVER, else -> SERVE.
  - Presses are dropped.
  - Total cycles spent in ROUND_END = HOLDOFF.
- MATCH_OVER:
  - match_over=1; winner=1 if user_score==WIN_SCORE.
  - Scores held for display.
  - start=1 -> SERVE with both scores cleared to 0 on the same edge.
- Arithmetic:
  - Scores are 3-bit unsigned and never exceed WIN_SCORE; no wrap can occur.
  - Only one score can increment per cycle.
- Output timing:
  - move_l, move_r and field_reset are each high for exactly one cycle per event, never two consecutive cycles from a single event.
  - move_l and move_r are never high together.
- Reset mid-operation: reset asserted in any state forces IDLE and zeroes everything immediately, without waiting for a clock.

Test Plan:
- Reset, start=1 for 1 cycle -> field_reset pulse on the 2nd cycle, round_active=1 from the 3rd cycle, both scores 0.
- PLAY, LED9=0, L pulse -> move_l=1 for exactly 1 cycle the next cycle. Simultaneous L=R=1 -> no move pulse, scores unchanged.
- PLAY, LED1=1, R pulse -> user_score 0->1, no move_r, round_active=0 for HOLDOFF=4 cycles, then a field_reset pulse, then PLAY.
- Computer wins 7 rounds (L with LED9=1 each round) -> after the 7th round plus holdoff: match_over=1, winner=0, comp_score=7. Further L/R have no effect.
- MATCH_OVER, start=1 -> both scores 0, field_reset pulse, PLAY. Presses during SERVE/ROUND_END produce no move pulses.
- Drop reset to 0 mid-ROUND_END with user_score=3 -> immediately IDLE, all outputs 0, no clock edge needed.
